// File: rtl/ce_mem_responder_pkg.sv
// Shared constants, types and the write-back saturation helper for ce_mem_responder.
package ce_mem_responder_pkg;
  localparam int unsigned Ba       = 8;
  localparam int unsigned Bm       = 6;
  localparam int unsigned Bd       = 16;
  localparam int unsigned FRAC     = 8;
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned N        = 2 ** Bm;
  localparam int unsigned ACC_W    = 2 * Bd + Ba;

  typedef enum logic {BANK0 = 1'b0, BANK1 = 1'b1} bank_t;

  typedef struct packed {
    logic                 clip;
    logic signed [Bd-1:0] val;
  } sat_t;

  // Clamp an accumulator-width value into the signed Bd range.
  function automatic sat_t sat_bd(input logic signed [ACC_W-1:0] x);
    sat_t r;
    logic signed [ACC_W-1:0] maxv;
    logic signed [ACC_W-1:0] minv;
    maxv = {{(ACC_W-Bd+1){1'b0}}, {(Bd-1){1'b1}}};
    minv = {{(ACC_W-Bd+1){1'b1}}, {(Bd-1){1'b0}}};
    if (x > maxv) begin
      r.val  = maxv[Bd-1:0];
      r.clip = 1'b1;
    end else if (x < minv) begin
      r.val  = minv[Bd-1:0];
      r.clip = 1'b1;
    end else begin
      r.val  = x[Bd-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction
endpackage

// File: rtl/ce_mem_responder_if.sv
// Sequencing/load bus between controlengine (master) and ce_mem_responder (slave).
interface ce_mem_responder_if;
  import ce_mem_responder_pkg::*;

  logic [Ba-1:0] rd_step;
  logic [Ba-1:0] wr_step;
  logic [Bm-1:0] source_addr;
  logic [Bm-1:0] dest_addr;
  logic          wren;
  logic [Bd-1:0] w_in;
  logic          layer_done;
  logic          load_en;
  logic [Bm-1:0] load_addr;
  logic [Bd-1:0] load_data;
  logic [Bd-1:0] rd_data;
  logic          wr_pulse;
  logic [Ba-1:0] wr_idx;
  logic          bank_sel;
  logic          busy;
  logic          sat;

  modport master (
    output rd_step, wr_step, source_addr, dest_addr, wren, w_in,
           layer_done, load_en, load_addr, load_data,
    input  rd_data, wr_pulse, wr_idx, bank_sel, busy, sat
  );

  modport slave (
    input  rd_step, wr_step, source_addr, dest_addr, wren, w_in,
           layer_done, load_en, load_addr, load_data,
    output rd_data, wr_pulse, wr_idx, bank_sel, busy, sat
  );
endinterface

// File: rtl/ce_mem_responder_ram.sv
// ce_dual_bank_ram: ping-pong activation store. Registered read from the read bank,
// host writes land in the read bank, engine writes in the other one.
module ce_dual_bank_ram
  import ce_mem_responder_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  bank_t                i_rd_bank,
  input  logic [Bm-1:0]        i_rd_addr,
  output logic signed [Bd-1:0] o_rd_data,
  input  logic                 i_eng_we,
  input  logic [Bm-1:0]        i_eng_addr,
  input  logic [Bd-1:0]        i_eng_data,
  input  logic                 i_host_we,
  input  logic [Bm-1:0]        i_host_addr,
  input  logic [Bd-1:0]        i_host_data
);
  logic [Bd-1:0] r_mem0 [0:N-1];
  logic [Bd-1:0] r_mem1 [0:N-1];
  logic          w_we0, w_we1;
  logic [Bm-1:0] w_addr0, w_addr1;
  logic [Bd-1:0] w_data0, w_data1;
  logic signed [Bd-1:0] r_rd_data;

  // Each bank's single write port is owned by the host when it is the read bank, else by the engine.
  always_comb begin
    w_we0   = (i_rd_bank == BANK0) ? i_host_we   : i_eng_we;
    w_addr0 = (i_rd_bank == BANK0) ? i_host_addr : i_eng_addr;
    w_data0 = (i_rd_bank == BANK0) ? i_host_data : i_eng_data;
    w_we1   = (i_rd_bank == BANK1) ? i_host_we   : i_eng_we;
    w_addr1 = (i_rd_bank == BANK1) ? i_host_addr : i_eng_addr;
    w_data1 = (i_rd_bank == BANK1) ? i_host_data : i_eng_data;
  end

  // Bank storage; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_we0) r_mem0[w_addr0] <= w_data0;
    if (w_we1) r_mem1[w_addr1] <= w_data1;
  end

  // Registered read port; a same-cycle write to the same word returns the old value.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= (i_rd_bank == BANK0) ? r_mem0[i_rd_addr] : r_mem1[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/ce_mem_responder.sv
// ce_mem_responder: MAC responder owning the ping-pong activation memory.
// Optional feature: define CE_RESP_RELU_EN to clamp negative write-backs to zero.
module ce_mem_responder
  import ce_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ce_mem_responder_if.slave bus
);
  logic [PIPE_LAT-1:0]     r_wren_dly;
  logic [Bm-1:0]           r_dest_s1;
  logic [Ba-1:0]           r_wstep_s1;
  logic [Ba-1:0]           r_rstep_s1;
  logic signed [Bd-1:0]    r_w_s1;
  logic signed [ACC_W-1:0] r_acc;
  bank_t                   r_bank_sel;
  logic                    r_pending;
  logic                    r_wr_pulse;
  logic [Ba-1:0]           r_wr_idx;
  logic                    r_sat;

  logic signed [Bd-1:0]    w_rd_data;
  logic signed [ACC_W-1:0] w_a, w_b, w_prod, w_acc_next;
  sat_t                    w_sat;
  logic signed [Bd-1:0]    w_wb_val;
  logic                    w_wb_clip;
  logic                    w_eng_we;
  logic                    w_busy;

  assign w_busy   = |r_wren_dly;
  // Write-back commits from the S1 product so the result lands together with wr_pulse.
  assign w_eng_we = r_wren_dly[0] & ~rst;

  ce_dual_bank_ram u_ram (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_bank   (r_bank_sel),
    .i_rd_addr   (bus.source_addr),
    .o_rd_data   (w_rd_data),
    .i_eng_we    (w_eng_we),
    .i_eng_addr  (r_dest_s1),
    .i_eng_data  (w_wb_val),
    .i_host_we   (bus.load_en),
    .i_host_addr (bus.load_addr),
    .i_host_data (bus.load_data)
  );

  // MAC datapath and saturating write-back value.
  always_comb begin
    w_a        = ACC_W'(w_rd_data);
    w_b        = ACC_W'(r_w_s1);
    w_prod     = w_a * w_b;
    w_acc_next = (r_rstep_s1 == '0) ? w_prod : r_acc + w_prod;
    w_sat      = sat_bd(w_acc_next >>> FRAC);
    w_wb_val   = w_sat.val;
    w_wb_clip  = w_sat.clip;
`ifdef CE_RESP_RELU_EN
    if (w_sat.val[Bd-1]) begin
      w_wb_val  = '0;
      w_wb_clip = 1'b0;
    end
`endif
  end

  // Pipeline alignment, accumulator, commit reporting and deferred bank swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wren_dly <= '0;
      r_dest_s1  <= '0;
      r_wstep_s1 <= '0;
      r_rstep_s1 <= '0;
      r_w_s1     <= '0;
      r_acc      <= '0;
      r_bank_sel <= BANK0;
      r_pending  <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_idx   <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_wren_dly <= {r_wren_dly[PIPE_LAT-2:0], bus.wren};
      r_dest_s1  <= bus.dest_addr;
      r_wstep_s1 <= bus.wr_step;
      r_rstep_s1 <= bus.rd_step;
      r_w_s1     <= bus.w_in;
      r_acc      <= w_acc_next;
      r_wr_pulse <= r_wren_dly[0];
      if (r_wren_dly[0]) begin
        r_wr_idx <= r_wstep_s1;
        r_sat    <= r_sat | w_wb_clip;
      end
      // layer_done arriving while a swap is pending (incl. the swap cycle) is absorbed.
      if (r_pending && !w_busy) begin
        r_bank_sel <= (r_bank_sel == BANK0) ? BANK1 : BANK0;
        r_pending  <= 1'b0;
      end else if (bus.layer_done) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.wr_pulse = r_wr_pulse;
  assign bus.wr_idx   = r_wr_idx;
  assign bus.bank_sel = r_bank_sel;
  assign bus.busy     = w_busy;
  assign bus.sat      = r_sat;
endmodule

// File: tb/tb_ce_mem_responder.sv
// Scoreboard bench for ce_mem_responder: random MAC jobs checked against an array model.
module tb_ce_mem_responder;
  import ce_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ce_mem_responder_if bus();
  ce_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic [15:0] data; } rd_exp_t;
  typedef struct { int cyc; logic [7:0] idx; bit sat; } wr_exp_t;

  rd_exp_t     rdq[$];
  wr_exp_t     wrq[$];
  logic [15:0] mmem [2][64];
  int          bsel;
  bit          msat;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] wb_val(input longint s, output bit clip);
    longint v;
    v = s >>> 8;
    clip = 1'b0;
    if (v > 32767) begin v = 32767; clip = 1'b1; end
    else if (v < -32768) begin v = -32768; clip = 1'b1; end
`ifdef CE_RESP_RELU_EN
    if (v < 0) begin v = 0; clip = 1'b0; end
`endif
    return 16'(v);
  endfunction

  task automatic push_rd(input logic [15:0] d);
    rd_exp_t e;
    e.cyc = cyc; e.data = d;
    rdq.push_back(e);
  endtask

  task automatic push_wr(input logic [7:0] idx, input bit s);
    wr_exp_t e;
    e.cyc = cyc; e.idx = idx; e.sat = s;
    wrq.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.rd_step = '0; bus.wr_step = '0; bus.source_addr = '0; bus.dest_addr = '0;
    bus.wren = 1'b0; bus.w_in = '0; bus.layer_done = 1'b0;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic load(input logic [5:0] a, input logic [15:0] d, input bit rd);
    next_cycle();
    bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
    if (rd) begin bus.source_addr = a; push_rd(mmem[bsel][a]); end
    mmem[bsel][a] = d;
  endtask

  task automatic read(input logic [5:0] a);
    next_cycle();
    bus.source_addr = a;
    push_rd(mmem[bsel][a]);
  endtask

  task automatic swap();
    next_cycle();
    bus.layer_done = 1'b1;
    idle(4);
    bsel = 1 - bsel;
    chk("bank_sel_swap", bus.bank_sel, bsel);
  endtask

  // One output: n terms dotted against the read bank, result committed on the last term.
  task automatic job(input int n, input logic [5:0] sa[4], input logic [15:0] wa[4],
                     input logic [5:0] dst, input logic [7:0] wstep, input bit commit);
    longint s;
    bit clip;
    s = 0;
    for (int i = 0; i < n; i++) begin
      next_cycle();
      bus.rd_step = 8'(i); bus.source_addr = sa[i]; bus.w_in = wa[i];
      bus.dest_addr = dst; bus.wr_step = wstep;
      push_rd(mmem[bsel][sa[i]]);
      s += longint'($signed(mmem[bsel][sa[i]])) * longint'($signed(wa[i]));
      if (i == n - 1) begin
        bus.wren = 1'b1;
        if (commit) begin
          mmem[1-bsel][dst] = wb_val(s, clip);
          msat = msat | clip;
          push_wr(wstep, msat);
        end
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or a commit pulse.
  rd_exp_t mr;
  wr_exp_t mw;
  always @(negedge clk) begin
    if (rdq.size() > 0 && rdq[0].cyc == cyc - 1) begin
      mr = rdq.pop_front();
      chk("rd_data", bus.rd_data, mr.data);
    end else if (rdq.size() > 0 && rdq[0].cyc < cyc - 1) begin
      mr = rdq.pop_front();
      total++; bad++;
      $display("FAIL rd_stale: entry from cycle %0d never checked (now %0d)", mr.cyc, cyc);
    end
    if (bus.wr_pulse === 1'b1) begin
      if (wrq.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_pulse_unexpected: got 1 required 0 at cycle %0d", cyc);
      end else begin
        mw = wrq.pop_front();
        chk("wr_latency", 40'(cyc), 40'(mw.cyc + 2));
        chk("wr_idx", bus.wr_idx, mw.idx);
        chk("sat", bus.sat, mw.sat);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  sa[4];
    logic [15:0] wa[4];
    int          k, sw, tbank;
    logic [5:0]  d;
    idle_inputs();
    bsel = 0; msat = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_wr_pulse", bus.wr_pulse, 0);
    chk("rst_wr_idx", bus.wr_idx, 0);
    chk("rst_bank_sel", bus.bank_sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sat", bus.sat, 0);
    swap();

    // Reset with clocks running, t=300..400.
    while ($time < 300) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_bank_sel", bus.bank_sel, 0);
    chk("rst2_wr_pulse", bus.wr_pulse, 0);
    chk("rst2_busy", bus.busy, 0);
    chk("rst2_rd_data", bus.rd_data, 0);
    while ($time < 400) @(negedge clk);
    rst = 1'b0;
    bsel = 0; msat = 1'b0;

    // Fill both banks so every model word is known.
    for (int a = 0; a < 64; a++) load(6'(a), 16'($urandom), 1'b0);
    swap();
    for (int a = 0; a < 64; a++) load(6'(a), 16'($urandom), 1'b0);
    swap();

    // 4 x (1.0 * 1.0) -> 4.0 at dest 5.
    for (int a = 0; a < 4; a++) load(6'(a), 16'd256, 1'b0);
    for (int i = 0; i < 4; i++) begin sa[i] = 6'(i); wa[i] = 16'd256; end
    job(4, sa, wa, 6'd5, 8'd3, 1'b1);
    idle(3);
    chk("sat_after_unity", bus.sat, 0);

    // Large negative result: clip low, or zero under ReLU.
    for (int a = 8; a < 12; a++) load(6'(a), 16'h7FFF, 1'b0);
    for (int i = 0; i < 4; i++) begin sa[i] = 6'(8 + i); wa[i] = 16'hFF00; end
    job(4, sa, wa, 6'd6, 8'd4, 1'b1);
    idle(3);
    chk("sat_after_neg", bus.sat, msat);
    // Large positive result saturates high.
    for (int i = 0; i < 4; i++) wa[i] = 16'h7FFF;
    job(4, sa, wa, 6'd7, 8'd5, 1'b1);

    // layer_done one cycle after wren: swap must wait for the commit.
    for (int i = 0; i < 4; i++) begin sa[i] = 6'(i); wa[i] = 16'd256; end
    job(2, sa, wa, 6'd9, 8'd9, 1'b1);
    k = cyc;
    next_cycle();
    bus.layer_done = 1'b1;
    sw = -1;
    for (int i = 0; i < 10 && sw < 0; i++) begin
      next_cycle();
      if (bus.bank_sel !== bsel[0]) sw = cyc;
    end
    chk("swap_seen", 40'(sw >= 0), 1);
    chk("swap_after_pulse", 40'(sw > k + 2), 1);
    bsel = 1 - bsel;
    read(6'd5); read(6'd6); read(6'd7); read(6'd9);

    // Host load and read of the same word in one cycle.
    load(6'd7, 16'd10, 1'b0);
    load(6'd7, 16'd20, 1'b1);
    read(6'd7);

    // Random back-to-back jobs with interleaved loads, then read back after a swap.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 12; j++) begin
        for (int i = 0; i < 4; i++) begin
          sa[i] = 6'($urandom);
          wa[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                              : 16'(int'($urandom_range(0, 1024)) - 512);
        end
        job(int'($urandom_range(1, 4)), sa, wa, 6'($urandom), 8'($urandom), 1'b1);
        if ($urandom_range(0, 3) == 0) load(6'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end
      swap();
      for (int i = 0; i < 16; i++) read(6'($urandom));
    end

    // Reset one cycle after wren: the commit must vanish.
    d = 6'($urandom);
    tbank = 1 - bsel;
    for (int i = 0; i < 4; i++) begin sa[i] = 6'($urandom); wa[i] = 16'($urandom); end
    job(3, sa, wa, d, 8'd77, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    bsel = 0; msat = 1'b0;
    chk("rst3_wr_pulse", bus.wr_pulse, 0);
    chk("rst3_busy", bus.busy, 0);
    chk("rst3_bank_sel", bus.bank_sel, 0);
    chk("rst3_sat", bus.sat, 0);
    idle(3);
    if (tbank != bsel) swap();
    read(d);

    idle(5);
    chk("rdq_drained", 40'(rdq.size()), 0);
    chk("wrq_drained", 40'(wrq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
